// File: rtl/sdp_y_core_triosy_pkg.sv
// sdp_y_core_triosy_pkg: shared parameter limits and count-width helper for the triosy wait cores.
package sdp_y_core_triosy_pkg;

    localparam int NCH_MIN   = 1;
    localparam int NCH_MAX   = 16;
    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 15;

    // Width needed to hold every value 0..depth.
    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sdp_y_core_triosy_wait_chan.sv
// sdp_y_core_triosy_wait_chan: one triosy wait channel with a saturating pending-event counter.
// Ports: clk_i/rst_i (sync, active-high); biwt_i event issue; bdwt_i downstream stall;
//        flush_i drops pending events; ovf_clr_i clears the sticky overflow flag;
//        bawt_o event available; cnt_o pending count; full_o count at DEPTH; ovf_o sticky drop flag.
module sdp_y_core_triosy_wait_chan
    import sdp_y_core_triosy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = calc_cw(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          biwt_i,
    input  logic          bdwt_i,
    input  logic          flush_i,
    input  logic          ovf_clr_i,
    output logic          bawt_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          ovf_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          consume;
    logic [CW:0]   sum;
    logic          over;

    // A consume at count 0 implies biwt is high, so the extra bit never sees an underflow.
    always_comb begin
        bawt_o  = biwt_i | (cnt_q != '0);
        consume = bawt_o & ~bdwt_i;
        sum     = {1'b0, cnt_q} + {{CW{1'b0}}, biwt_i} - {{CW{1'b0}}, consume};
        over    = sum > (CW+1)'(DEPTH);
        cnt_d   = flush_i ? '0 : over ? CW'(DEPTH) : sum[CW-1:0];
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d   = over | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign full_o = cnt_q == CW'(DEPTH);
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/sdp_y_core_triosy_wait_dp_multi.sv
// sdp_y_core_triosy_wait_dp_multi: NCH independent triosy wait channels with pending-event counters.
// Ports: nvdla_core_clk/nvdla_core_rst (sync, active-high); biwt/bdwt per-channel issue and stall;
//        flush, ovf_clr global; bawt per-channel available, all_bawt AND of bawt;
//        pend_cnt packed counts (channel i at [i*CW +: CW]); full, ovf per channel.
module sdp_y_core_triosy_wait_dp_multi
    import sdp_y_core_triosy_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int DEPTH = 4,
    localparam int CW    = calc_cw(DEPTH)
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic [NCH-1:0]    biwt,
    input  logic [NCH-1:0]    bdwt,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic [NCH-1:0]    bawt,
    output logic              all_bawt,
    output logic [NCH*CW-1:0] pend_cnt,
    output logic [NCH-1:0]    full,
    output logic [NCH-1:0]    ovf
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        sdp_y_core_triosy_wait_chan #(.DEPTH(DEPTH), .CW(CW)) u_chan (
            .clk_i     (nvdla_core_clk),
            .rst_i     (nvdla_core_rst),
            .biwt_i    (biwt[i]),
            .bdwt_i    (bdwt[i]),
            .flush_i   (flush),
            .ovf_clr_i (ovf_clr),
            .bawt_o    (bawt[i]),
            .cnt_o     (pend_cnt[i*CW +: CW]),
            .full_o    (full[i]),
            .ovf_o     (ovf[i])
        );
    end

    assign all_bawt = &bawt;

endmodule

// File: doc/sdp_y_core_triosy_wait_dp_multi.md
SDP_Y_CORE_TRIOSY_WAIT_DP_MULTI -- requirements
Module: sdp_y_core_triosy_wait_dp_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent triosy wait channels (1..16).
REQ-002 SHALL have parameter DEPTH, default 4, maximum pending events held per channel (1..15).
REQ-003 SHALL derive CW = clog2(DEPTH+1), pending-count width per channel.
REQ-004 SHALL have one clock and a synchronous, active-high reset: nvdla_core_clk  in  1  sole clock, rising edge.
REQ-005 nvdla_core_rst  in  1  synchronous active-high reset.
REQ-006 biwt  in  NCH  per-channel event issue this cycle.
REQ-007 bdwt  in  NCH  per-channel downstream stall; consumption is blocked while high.
REQ-008 flush  in  1  discard all pending events.
REQ-009 ovf_clr  in  1  clear sticky overflow flags.
REQ-010 bawt  out  NCH  per-channel event available: biwt[i] OR pend_cnt[i] != 0.
REQ-011 all_bawt  out  1  AND of all bawt bits.
REQ-012 pend_cnt  out  NCH*CW  registered pending count; channel i occupies bits [i*CW +: CW].
REQ-013 full  out  NCH  pend_cnt[i] == DEPTH.
REQ-014 ovf  out  NCH  sticky flag: an event was dropped on channel i.

Function
REQ-015 Channels SHALL be fully independent; no state is shared except flush, ovf_clr and reset.
REQ-016 bawt[i] SHALL be combinational from biwt[i] and the registered count, giving zero-latency pass-through.
REQ-017 consume[i] SHALL equal bawt[i] AND NOT bdwt[i].
REQ-018 Next count SHALL be pend_cnt[i] + biwt[i] - consume[i], computed at CW+1 bits.
REQ-019 When the computed value exceeds DEPTH, the count SHALL saturate at DEPTH and ovf[i] SHALL be set on the next edge.
REQ-020 Count SHALL never go below 0; consume with count 0 only occurs with biwt high, so the event passes through and the count stays 0.
REQ-021 Simultaneous biwt and consume SHALL leave the count unchanged, including at full.
REQ-022 A channel at full with biwt=1 and bdwt=1 SHALL drop the event and set ovf[i].
REQ-023 flush SHALL zero all counts on the next edge, overriding biwt and consume that cycle.
REQ-024 bawt SHALL still reflect biwt during a flush cycle; that event is not retained.
REQ-025 ovf_clr SHALL clear all ovf bits, but an overflow in the same cycle SHALL win and leave that bit set.
REQ-026 With DEPTH=1 and biwt never asserted while bawt is held high, behaviour SHALL equal the legacy single-flag wait_dp: bcwt_next = bawt AND NOT bdwt.

Reset
REQ-027 Reset SHALL set pend_cnt=0 and ovf=0; hence bawt=biwt, full=0, and all_bawt=&biwt.
REQ-028 Reset SHALL take priority over flush, ovf_clr and events; reset mid-operation discards pending events with no ovf indication.

Structure
REQ-029 The CW calculation function and the NCH/DEPTH limit constants SHALL reside in shared package sdp_y_core_triosy_pkg.
REQ-030 Per-channel count, saturation and overflow logic SHALL be one sub-module, sdp_y_core_triosy_wait_chan, instantiated NCH times by generate.
REQ-031 The top level SHALL contain only the generate loop, all_bawt reduction and output packing.

Verification
REQ-032 Reset: NCH=4, DEPTH=4, rst=1 with biwt=4'hF -> pend_cnt all 0, ovf=0, bawt=4'hF; after release with biwt=0 -> bawt=0.
REQ-033 Backpressure fill: ch0 biwt=1 and bdwt=1 for 6 cycles -> count 1,2,3,4,4,4; full[0]=1 from cycle 4; ovf[0]=1 after cycle 5; other channels unchanged.
REQ-034 Drain: ch0 count=4, biwt=0, bdwt=0 -> count 3,2,1,0 on successive edges; bawt[0]=1 for 4 cycles, then 0.
REQ-035 Simultaneous: count=4, biwt=1, bdwt=0 -> count stays 4, ovf unchanged; count=0, biwt=1, bdwt=0 -> count stays 0, bawt=1.
REQ-036 Flush/clear race: counts {2,4,1,3}, flush=1 and ovf_clr=1 in the same cycle as an overflow on ch1 -> all counts 0, ovf=4'b0010.
REQ-037 Legacy equivalence: DEPTH=1, NCH=1, random biwt gated by !bawt with random bdwt -> matches the reference bcwt model cycle-for-cycle over 10k cycles.
